// File: rtl/y86_pkg.sv
// Shared Y86 constants: instruction codes, status codes and the
// memory-access FSM state type.
package y86_pkg;

    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    localparam logic [3:0] SAOK = 4'd1;
    localparam logic [3:0] SHLT = 4'd2;
    localparam logic [3:0] SADR = 4'd3;
    localparam logic [3:0] SINS = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_bytearray.sv
// Byte-addressed data memory with one 8-byte little-endian port.
// Ports: clk_i; i_we write enable; i_addr byte address; i_wdata write
// data; o_rdata combinational read of bytes i_addr..i_addr+7.
module dmem_bytearray
    import y86_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int ADDR_W      = 64
) (
    input  logic              clk_i,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [63:0]       i_wdata,
    output logic [63:0]       o_rdata
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic [7:0]        r_mem [DEPTH_BYTES];
    logic [ADDR_W-1:0] w_ridx;

    // Bytes past the end read as zero; the caller only uses in-range data.
    always_comb begin
        o_rdata = '0;
        w_ridx  = '0;
        for (int k = 0; k < 8; k++) begin
            w_ridx = i_addr + ADDR_W'(k);
            if (w_ridx < ADDR_W'(DEPTH_BYTES))
                o_rdata[8*k +: 8] = r_mem[AW'(w_ridx)];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < 8; k++) begin
            if (i_we && ((i_addr + ADDR_W'(k)) < ADDR_W'(DEPTH_BYTES)))
                r_mem[AW'(i_addr + ADDR_W'(k))] <= i_wdata[8*k +: 8];
        end
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Multi-cycle Y86 memory-access stage: one request per handshake, the
// 8-byte access commits after WAIT_CYCLES wait states, then a held
// response. Ports: clk_i/rst_i (sync, active high); req_valid_i/
// req_ready_o request handshake; icode_i, valE_i, valA_i, valP_i,
// instr_valid_i, imem_error_i request fields; rsp_valid_o/rsp_ready_i
// response handshake; valM_o read data; Stat_o status.
// Optional macro DMEM_ALIGN_CHECK_EN: unaligned accesses raise SADR.
module dmem_access_unit
    import y86_pkg::*;
#(
    parameter int DEPTH_BYTES = 1024,
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [3:0]        icode_i,
    input  logic [ADDR_W-1:0] valE_i,
    input  logic [63:0]       valA_i,
    input  logic [63:0]       valP_i,
    input  logic              instr_valid_i,
    input  logic              imem_error_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [63:0]       valM_o,
    output logic [3:0]        Stat_o
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

    dmem_state_e       r_state;
    logic [CW-1:0]     r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [63:0]       r_wdata;
    logic              r_wr;
    logic              r_rd;
    logic [3:0]        r_pstat;
    logic [63:0]       r_valM;
    logic [3:0]        r_stat;

    logic              w_is_wr;
    logic              w_is_rd;
    logic [ADDR_W-1:0] w_addr;
    logic [63:0]       w_wdata;
    logic              w_err;
    logic              w_perform;
    logic [3:0]        w_stat;
    logic              w_accept;
    logic              w_commit;
    logic              w_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [63:0]       w_mem_wdata;
    logic [63:0]       w_mem_rdata;

    always_comb begin
        w_is_wr = (icode_i == IRMMOVQ) || (icode_i == IPUSHQ)
               || (icode_i == ICALL);
        w_is_rd = (icode_i == IMRMOVQ) || (icode_i == IRET)
               || (icode_i == IPOPQ);
        w_addr  = ((icode_i == IRET) || (icode_i == IPOPQ))
                ? ADDR_W'(valA_i) : valE_i;
        w_wdata = (icode_i == ICALL) ? valP_i : valA_i;
        // Full-width unsigned compare: huge addresses never wrap in range.
        w_err   = (w_is_wr || w_is_rd)
               && (w_addr > ADDR_W'(DEPTH_BYTES - 8));
`ifdef DMEM_ALIGN_CHECK_EN
        w_err   = w_err
               || ((w_is_wr || w_is_rd) && (w_addr[2:0] != 3'd0));
`endif
        w_perform = (w_is_wr || w_is_rd) && !w_err
                 && !imem_error_i && instr_valid_i;
        if (imem_error_i || w_err)
            w_stat = SADR;
        else if (!instr_valid_i)
            w_stat = SINS;
        else if (icode_i == IHALT)
            w_stat = SHLT;
        else
            w_stat = SAOK;
    end

    assign w_accept = (r_state == IDLE) && req_valid_i;

    // With zero wait states the access happens on the accepting edge,
    // so the memory port sees the live request instead of the latch.
    assign w_commit    = (r_state == WAIT) && (r_cnt == '0);
    assign w_mem_addr  = (r_state == IDLE) ? w_addr : r_addr;
    assign w_mem_wdata = (r_state == IDLE) ? w_wdata : r_wdata;
    assign w_we = (w_accept && w_perform && w_is_wr && (WAIT_CYCLES == 0))
               || (w_commit && r_wr);

    dmem_bytearray #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .ADDR_W      (ADDR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .i_we    (w_we),
        .i_addr  (w_mem_addr),
        .i_wdata (w_mem_wdata),
        .o_rdata (w_mem_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_pstat <= SAOK;
            r_valM  <= '0;
            r_stat  <= SAOK;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_wr    <= w_perform && w_is_wr;
                        r_rd    <= w_perform && w_is_rd;
                        r_pstat <= w_stat;
                        if (w_perform && (WAIT_CYCLES > 0)) begin
                            r_state <= WAIT;
                            r_cnt   <= CNT_LOAD;
                        end else begin
                            r_state <= RESP;
                            r_valM  <= (w_perform && w_is_rd)
                                     ? w_mem_rdata : '0;
                            r_stat  <= w_stat;
                        end
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= RESP;
                        r_valM  <= r_rd ? w_mem_rdata : '0;
                        r_stat  <= r_pstat;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (r_state == IDLE);
    assign rsp_valid_o = (r_state == RESP);
    assign valM_o      = r_valM;
    assign Stat_o      = r_stat;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: directed scenarios plus
// randomized requests checked against a byte-array reference model.
module tb_dmem_access_unit;

    localparam int DEPTH = 1024;
    localparam int WC    = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  icode_i = '0;
    logic [63:0] valE_i = '0;
    logic [63:0] valA_i = '0;
    logic [63:0] valP_i = '0;
    logic        instr_valid_i = 1'b1;
    logic        imem_error_i = 1'b0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [63:0] valM_o;
    logic [3:0]  Stat_o;

    int n_asserts = 0;
    int n_fails   = 0;

    logic [7:0] mem_m [DEPTH];

    always #5 clk_i = ~clk_i;

    dmem_access_unit #(
        .DEPTH_BYTES (DEPTH),
        .WAIT_CYCLES (WC),
        .ADDR_W      (64)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .icode_i       (icode_i),
        .valE_i        (valE_i),
        .valA_i        (valA_i),
        .valP_i        (valP_i),
        .instr_valid_i (instr_valid_i),
        .imem_error_i  (imem_error_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_ready_i   (rsp_ready_i),
        .valM_o        (valM_o),
        .Stat_o        (Stat_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: behaviour derived from the operation rules directly.
    task automatic model(input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] va, input logic [63:0] vp,
                         input logic iv, input logic ie,
                         output logic [3:0] st, output logic [63:0] vm,
                         output int lat, output bit wr,
                         output logic [63:0] wa, output logic [63:0] wd);
        bit rd, w, err, ok;
        logic [63:0] a;
        rd  = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        w   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        a   = ((ic == 4'h9) || (ic == 4'hB)) ? va : ve;
        err = (rd || w) && (a > 64'(DEPTH - 8));
`ifdef DMEM_ALIGN_CHECK_EN
        if ((rd || w) && (a % 8 != 0)) err = 1'b1;
`endif
        ok = (rd || w) && !err && !ie && iv;
        if (ie || err)    st = 4'd3;
        else if (!iv)     st = 4'd4;
        else if (ic == 0) st = 4'd2;
        else              st = 4'd1;
        vm = '0;
        if (ok && rd)
            for (int k = 0; k < 8; k++)
                vm[8*k +: 8] = mem_m[int'(a) + k];
        lat = ok ? 1 + WC : 1;
        wr  = ok && w;
        wa  = a;
        wd  = (ic == 4'h8) ? vp : va;
    endtask

    // Called at a negedge; returns just after the accepting posedge.
    task automatic issue(input logic [3:0] ic, input logic [63:0] ve,
                         input logic [63:0] va, input logic [63:0] vp,
                         input logic iv, input logic ie);
        chk("req_ready_idle", 64'(req_ready_o), 64'd1);
        icode_i = ic; valE_i = ve; valA_i = va; valP_i = vp;
        instr_valid_i = iv; imem_error_i = ie; req_valid_i = 1'b1;
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
    endtask

    // Full transaction; starts and ends at a negedge.
    task automatic xact(input logic [3:0] ic, input logic [63:0] ve,
                        input logic [63:0] va, input logic [63:0] vp,
                        input logic iv, input logic ie, input int hold,
                        output logic [63:0] obs_vm,
                        output logic [3:0] obs_st);
        logic [3:0]  st;
        logic [63:0] vm, wa, wd;
        int          lat, n;
        bit          wr;
        model(ic, ve, va, vp, iv, ie, st, vm, lat, wr, wa, wd);
        issue(ic, ve, va, vp, iv, ie);
        n = 1;
        @(negedge clk_i);
        while (!rsp_valid_o && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        chk("latency", 64'(n), 64'(lat));
        chk("valM", valM_o, vm);
        chk("Stat", 64'(Stat_o), 64'(st));
        obs_vm = valM_o;
        obs_st = Stat_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            chk("stall_valid", 64'(rsp_valid_o), 64'd1);
            chk("stall_valM", valM_o, vm);
            chk("stall_Stat", 64'(Stat_o), 64'(st));
            chk("stall_req_ready", 64'(req_ready_o), 64'd0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1 rsp_ready_i = 1'b0;
        if (wr)
            for (int k = 0; k < 8; k++)
                mem_m[int'(wa) + k] = wd[8*k +: 8];
        @(negedge clk_i);
        chk("rsp_valid_drop", 64'(rsp_valid_o), 64'd0);
    endtask

    function automatic logic [63:0] rnd_addr();
        int m;
        m = int'($urandom_range(0, 7));
        if (m <= 4) return 64'($urandom_range(0, DEPTH / 8 - 1) * 8);
        if (m == 5) return 64'($urandom_range(0, DEPTH - 8));
        if (m == 6) return 64'(DEPTH - 8 + int'($urandom_range(1, 16)));
        return {$urandom, $urandom};
    endfunction

    logic [3:0]  codes [12] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h7,
                                4'h8, 4'h9, 4'hA, 4'hB, 4'h6, 4'hF};
    logic [63:0] ovm;
    logic [3:0]  ost;
    logic [63:0] d;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_req_ready", 64'(req_ready_o), 64'd1);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_valM", valM_o, 64'd0);
        chk("rst_Stat", 64'(Stat_o), 64'd1);

        // Give every byte a known value.
        for (int i = 0; i < DEPTH / 8; i++) begin
            d = {$urandom, $urandom};
            xact(4'h4, 64'(i * 8), d, 0, 1, 0, 0, ovm, ost);
        end

        xact(4'h4, 64'h10, 64'h1122334455667788, 0, 1, 0, 0, ovm, ost);
        xact(4'h5, 64'h10, 0, 0, 1, 0, 0, ovm, ost);
        chk("raw_data", ovm, 64'h1122334455667788);
        chk("raw_stat", 64'(ost), 64'd1);

        xact(4'hA, 64'(DEPTH - 8), 64'hCAFEF00D12345678, 0, 1, 0, 0,
             ovm, ost);
        chk("push_top_stat", 64'(ost), 64'd1);
        xact(4'hB, 0, 64'(DEPTH - 8), 0, 1, 0, 0, ovm, ost);
        chk("pop_top_stat", 64'(ost), 64'd1);
        chk("pop_top_data", ovm, 64'hCAFEF00D12345678);
        xact(4'h5, 64'(DEPTH - 7), 0, 0, 1, 0, 0, ovm, ost);
        chk("oob_stat", 64'(ost), 64'd3);
        chk("oob_valM", ovm, 64'd0);
        xact(4'h5, 64'hFFFFFFFFFFFFFFF8, 0, 0, 1, 0, 0, ovm, ost);
        chk("huge_addr_stat", 64'(ost), 64'd3);

        xact(4'h4, 64'h20, 64'hA5A5A5A55A5A5A5A, 0, 1, 0, 0, ovm, ost);
        xact(4'h4, 64'h20, 64'hDEADBEEFDEADBEEF, 0, 1, 1, 0, ovm, ost);
        chk("imem_err_stat", 64'(ost), 64'd3);
        xact(4'h5, 64'h20, 0, 0, 1, 0, 0, ovm, ost);
        chk("suppressed_wr", ovm, 64'hA5A5A5A55A5A5A5A);
        xact(4'h5, 64'h20, 0, 0, 0, 0, 0, ovm, ost);
        chk("sins_stat", 64'(ost), 64'd4);
        chk("sins_valM", ovm, 64'd0);
        xact(4'h0, 0, 0, 0, 1, 0, 0, ovm, ost);
        chk("halt_stat", 64'(ost), 64'd2);

        xact(4'h5, 64'h10, 0, 0, 1, 0, 5, ovm, ost);

        xact(4'h4, 64'h40, 64'h0102030405060708, 0, 1, 0, 0, ovm, ost);
        issue(4'h8, 64'h40, 0, 64'hFFEEDDCCBBAA9988, 1, 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        chk("midrst_req_ready", 64'(req_ready_o), 64'd1);
        chk("midrst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("midrst_valM", valM_o, 64'd0);
        chk("midrst_Stat", 64'(Stat_o), 64'd1);
        xact(4'h5, 64'h40, 0, 0, 1, 0, 0, ovm, ost);
        chk("midrst_discard", ovm, 64'h0102030405060708);

        xact(4'h4, 64'h18, 64'h8877665544332211, 0, 1, 0, 0, ovm, ost);
        xact(4'h5, 64'h13, 0, 0, 1, 0, 0, ovm, ost);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("unaligned_stat", 64'(ost), 64'd3);
`else
        chk("unaligned_stat", 64'(ost), 64'd1);
        chk("unaligned_hi", 64'(ovm[63:40]), 64'h332211);
`endif

        for (int i = 0; i < 60; i++) begin
            logic [3:0]  ic;
            logic [63:0] ve, va;
            ic = codes[$urandom_range(0, 11)];
            ve = rnd_addr();
            va = ($urandom_range(0, 1) == 1) ? rnd_addr()
                                             : {$urandom, $urandom};
            xact(ic, ve, va, {$urandom, $urandom},
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 9) == 0),
                 int'($urandom_range(0, 2)), ovm, ost);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fails);
        $finish;
    end

endmodule
